ifetch_queue: RTL and testbench

- Decoupled instruction-fetch front end between the fetch PC register / synchronous InstructionRAM and the ID pipeline register.
- Generates sequential fetch addresses and captures returned instructions with their PC and PC+4 in a small FIFO.
- Presents the FIFO head to decode with a valid/ready handshake.
- A taken branch or jump resolved in ID redirects the fetch PC, flushes the queue, and kills any in-flight fetch.

---
 rtl/ifetch_queue.sv | 108 ++++++++++
 tb/tb_ifetch_queue.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// Decoupled instruction-fetch front end: sequential PC generation, a small FIFO of
// {instr, PC, PC+4} fed by a 1-cycle InstructionRAM, and branch/jump redirect flush.
module ifetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                       CLK,
   input  logic                       RSTn,
   input  logic                       RedirectValid,
   input  logic [31:0]                RedirectPC,
   output logic                       ImemReq,
   output logic [31:0]                ImemAddr,
   input  logic [31:0]                ImemData,
   output logic                       ValidOut,
   input  logic                       ReadyIn,
   output logic [31:0]                InstrOut,
   output logic [31:0]                PCOut,
   output logic [31:0]                PCPlus4Out,
   output logic [$clog2(DEPTH):0]     Count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

   logic [31:0]   fetchPC;
   logic [31:0]   reqPC;
   logic          inFlight;
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [AW:0]   count;

   logic [31:0]   instrMem [DEPTH];
   logic [31:0]   pcMem    [DEPTH];
   logic [31:0]   pc4Mem   [DEPTH];

   logic          push;
   logic          pop;
   logic          credit;
   logic [AW+1:0] occupancy;

   // Credit counts the in-flight fetch as occupied so a returning word always has a slot;
   // a pop in the same cycle frees one, keeping one fetch per cycle under backpressure release.
   always_comb begin
      push      = inFlight & ~RedirectValid;
      pop       = ValidOut & ReadyIn & ~RedirectValid;
      occupancy = {1'b0, count} + (AW+2)'(inFlight);
      credit    = (occupancy < (AW+2)'(DEPTH)) | pop;
      ImemReq   = credit & ~RedirectValid & RSTn;
      ImemAddr  = fetchPC;
   end

   always_comb begin
      ValidOut   = (count != '0);
      Count      = count;
      InstrOut   = '0;
      PCOut      = '0;
      PCPlus4Out = '0;
      if (ValidOut) begin
         InstrOut   = instrMem[head];
         PCOut      = pcMem[head];
         PCPlus4Out = pc4Mem[head];
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         fetchPC  <= RESET_PC;
         reqPC    <= '0;
         inFlight <= 1'b0;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
      end else if (RedirectValid) begin
         fetchPC  <= RedirectPC;
         inFlight <= 1'b0;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
      end else begin
         if (ImemReq) begin
            reqPC    <= fetchPC;
            fetchPC  <= fetchPC + 32'd4;
            inFlight <= 1'b1;
         end else begin
            inFlight <= 1'b0;
         end
         if (push) tail <= tail + PTR_ONE;
         if (pop)  head <= head + PTR_ONE;
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (push) begin
         instrMem[tail] <= ImemData;
         pcMem[tail]    <= reqPC;
         pc4Mem[tail]   <= reqPC + 32'd4;
      end
   end

   assert property (@(posedge CLK) disable iff (!RSTn) push |-> (count != (AW+1)'(DEPTH)));

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: cold start, backpressure, redirects, pointer wrap
// and asynchronous reset, against a 1-cycle IRAM whose word k is 32'h1000_0000+k.
module tb_ifetch_queue;

   logic        CLK = 1'b0;
   logic        RSTn;
   logic        RedirectValid;
   logic [31:0] RedirectPC;
   logic        ImemReq;
   logic [31:0] ImemAddr;
   logic [31:0] ImemData = '0;
   logic        ValidOut;
   logic        ReadyIn;
   logic [31:0] InstrOut;
   logic [31:0] PCOut;
   logic [31:0] PCPlus4Out;
   logic [2:0]  Count;

   int passCnt  = 0;
   int totalCnt = 0;

   ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .CLK(CLK), .RSTn(RSTn), .RedirectValid(RedirectValid), .RedirectPC(RedirectPC),
      .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemData(ImemData),
      .ValidOut(ValidOut), .ReadyIn(ReadyIn), .InstrOut(InstrOut),
      .PCOut(PCOut), .PCPlus4Out(PCPlus4Out), .Count(Count)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) if (ImemReq) ImemData <= 32'h1000_0000 + (ImemAddr >> 2);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      totalCnt++;
      assert (obs === exp) passCnt++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge CLK);
      #2;
   endtask

   // Returns in cycle 1 (first cycle with RSTn=1), 2 time units after its opening edge.
   task automatic doReset();
      RSTn = 1'b0;
      RedirectValid = 1'b0;
      #1;
      cyc();
      RSTn = 1'b1;
   endtask

   initial begin
      int pops;
      int waited;
      logic [31:0] expPC;
      logic cntBad;

      RSTn = 1'b0; RedirectValid = 1'b0; RedirectPC = '0; ReadyIn = 1'b0;
      #2;
      check("rst_valid", 32'(ValidOut), 32'd0);
      check("rst_req",   32'(ImemReq),  32'd0);
      check("rst_count", 32'(Count),    32'd0);
      check("rst_pc",    PCOut,         32'd0);
      check("rst_instr", InstrOut,      32'd0);
      check("rst_pc4",   PCPlus4Out,    32'd0);

      // Cold start with ReadyIn=1
      ReadyIn = 1'b1;
      doReset();
      #1;
      check("cold_req1",  32'(ImemReq), 32'd1);
      check("cold_addr1", ImemAddr,     32'd0);
      cyc(); #1;
      check("cold_addr2",  ImemAddr,       32'd4);
      check("cold_valid2", 32'(ValidOut),  32'd0);
      cyc(); #1;
      check("cold_valid3", 32'(ValidOut),  32'd1);
      check("cold_pc3",    PCOut,          32'd0);
      check("cold_instr3", InstrOut,       32'h1000_0000);
      check("cold_pc4_3",  PCPlus4Out,     32'd4);
      check("cold_addr3",  ImemAddr,       32'd8);
      for (int k = 1; k < 5; k++) begin
         cyc(); #1;
         check("stream_valid", 32'(ValidOut), 32'd1);
         check("stream_pc",    PCOut,         32'(4 * k));
         check("stream_instr", InstrOut,      32'h1000_0000 + 32'(k));
         check("stream_count", 32'(Count),    32'd1);
      end

      // Backpressure from reset
      ReadyIn = 1'b0;
      doReset();
      #1;
      for (int k = 0; k < 4; k++) begin
         check("bp_req",  32'(ImemReq), 32'd1);
         check("bp_addr", ImemAddr,     32'(4 * k));
         cyc(); #1;
      end
      check("bp_req5",   32'(ImemReq), 32'd0);
      check("bp_count5", 32'(Count),   32'd3);
      cyc(); #1;
      check("bp_count6", 32'(Count),   32'd4);
      check("bp_req6",   32'(ImemReq), 32'd0);
      check("bp_fpc6",   ImemAddr,     32'd16);
      check("bp_head6",  PCOut,        32'd0);
      cyc(); #1;
      check("bp_hold",   PCOut,        32'd0);
      ReadyIn = 1'b1;
      #1;
      check("bp_release_req", 32'(ImemReq), 32'd1);
      for (int k = 0; k < 5; k++) begin
         check("bp_pop_valid", 32'(ValidOut), 32'd1);
         check("bp_pop_pc",    PCOut,         32'(4 * k));
         cyc(); #1;
      end

      // Redirect with Count=3 and a fetch in flight
      ReadyIn = 1'b0;
      doReset();
      for (int k = 0; k < 4; k++) cyc();
      #1;
      check("rd_count_pre", 32'(Count), 32'd3);
      RedirectValid = 1'b1; RedirectPC = 32'h0000_0040;
      #1;
      check("rd_req_n", 32'(ImemReq), 32'd0);
      cyc();
      RedirectValid = 1'b0;
      #1;
      check("rd_count_n1", 32'(Count),    32'd0);
      check("rd_valid_n1", 32'(ValidOut), 32'd0);
      check("rd_req_n1",   32'(ImemReq),  32'd1);
      check("rd_addr_n1",  ImemAddr,      32'h40);
      cyc(); #1;
      check("rd_valid_n2", 32'(ValidOut), 32'd0);
      cyc(); #1;
      check("rd_valid_n3", 32'(ValidOut), 32'd1);
      check("rd_pc_n3",    PCOut,         32'h40);
      check("rd_instr_n3", InstrOut,      32'h1000_0010);
      ReadyIn = 1'b1;
      cyc(); #1;
      check("rd_pc_n4", PCOut, 32'h44);

      // Redirect while a pop would otherwise occur
      cyc(); #1;
      check("rdp_valid_pre", 32'(ValidOut), 32'd1);
      RedirectValid = 1'b1; RedirectPC = 32'h0000_0080;
      cyc();
      RedirectValid = 1'b0;
      #1;
      check("rdp_count", 32'(Count),    32'd0);
      check("rdp_valid", 32'(ValidOut), 32'd0);
      waited = 0;
      while (!ValidOut && waited < 10) begin
         cyc(); #1;
         waited++;
      end
      check("rdp_latency", 32'(waited), 32'd2);
      check("rdp_pc",      PCOut,       32'h80);

      // Pointer wrap with random ReadyIn
      doReset();
      pops = 0; expPC = '0; cntBad = 1'b0;
      for (int c = 0; c < 400 && pops < 13; c++) begin
         ReadyIn = 1'($urandom_range(0, 1));
         #1;
         if (Count > 3'd4) cntBad = 1'b1;
         if (ValidOut && ReadyIn) begin
            check("wrap_pc",  PCOut,      expPC);
            check("wrap_pc4", PCPlus4Out, expPC + 32'd4);
            expPC += 32'd4;
            pops++;
         end
         cyc();
      end
      check("wrap_pops",   32'(pops),   32'd13);
      check("wrap_cntmax", 32'(cntBad), 32'd0);

      // Asynchronous reset between edges with Count=2
      ReadyIn = 1'b0;
      doReset();
      for (int k = 0; k < 3; k++) cyc();
      #1;
      check("ar_count_pre", 32'(Count), 32'd2);
      #1;
      RSTn = 1'b0;
      #1;
      check("ar_valid", 32'(ValidOut), 32'd0);
      check("ar_count", 32'(Count),    32'd0);
      check("ar_req",   32'(ImemReq),  32'd0);
      cyc();
      RSTn = 1'b1;
      #1;
      check("ar_req_rel",  32'(ImemReq), 32'd1);
      check("ar_addr_rel", ImemAddr,     32'd0);

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
